regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 MIPS register file between two writeback sources: requester 0 (ALU/EX writeback) and requester 1 (load/MEM writeback). Each source uses a valid/ready handshake. The block performs round-robin arbitration and registers the winning write onto the register-file write-port signals (write enable, write address, write data). It filters writes to $zero and sits between the pipeline writeback stages and the register file.

Parameters:
AW, 5, register address width (32 registers)
DW, 32, write data width
STAT_W, 16, width of statistics counters (only with ARB_STATS_EN)

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  asynchronous reset, active-high
stall  input  1  freezes the write port; no grants while high
req0_valid  input  1  requester 0 has a pending write
req0_addr  input  AW  requester 0 destination register
req0_data  input  DW  requester 0 write data
req0_ready  output  1  requester 0 granted this cycle (combinational)
req1_valid  input  1  requester 1 has a pending write
req1_addr  input  AW  requester 1 destination register
req1_data  input  DW  requester 1 write data
req1_ready  output  1  requester 1 granted this cycle (combinational)
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  AW  register-file write address (registered)
rf_wdata  output  DW  register-file write data (registered)
grant_id  output  1  source of the current rf_* contents (registered)

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values, applied immediately on RST assertion: rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, rr_ptr=0 (requester 0 preferred).
- Reset mid-operation: any transfer not yet presented on rf_* is dropped. Requesters must re-present it after reset.
- Arbitration (combinational, every cycle):
  - stall=1: both readys are 0.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester indexed by rr_ptr is granted.
  - At most one ready is high in any cycle.
- rr_ptr update: on every transfer, rr_ptr <= index of the non-granted requester. With no transfer, rr_ptr holds.
- Transfer: occurs when reqX_valid && reqX_ready at the rising edge. Requesters hold valid, addr and data stable until ready; the bench asserts this. No combinational path exists from ready to valid.
- Output register, 1-cycle latency:
  - On a transfer: rf_we <= (addr != 0), rf_waddr <= addr, rf_wdata <= data, grant_id <= X.
  - With no transfer: rf_we <= 0; rf_waddr, rf_wdata and grant_id hold.
  - The register file commits the write at the edge after the transfer.
- Zero register: a write to address 0 is accepted (ready=1) and counts as a grant for rr_ptr, but rf_we stays 0.
- Same-address writes: when both requesters target the same register in one cycle, the writes serialise in round-robin order. Program ordering is the upstream pipeline's responsibility.
- Throughput: one write per cycle when not stalled. Requests that are continuously valid alternate grants, so neither requester starves.
- stall asserted: rf_we is 0 on the next cycle and rr_ptr is held. When stall deasserts, arbitration resumes from the held rr_ptr.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, the block adds outputs grant0_cnt, grant1_cnt and conflict_cnt, each STAT_W bits wide:
  - grant0_cnt and grant1_cnt increment on each transfer from requester 0 and requester 1 respectively.
  - conflict_cnt increments on each cycle with both valid and stall=0.
  - All counters saturate at all-ones and are cleared by RST.
- When not defined: no counters and no extra ports. Behaviour is otherwise identical.

Decomposition:
- Package regfile_arb_pkg: AW, DW, REG_ZERO=5'd0, grant id constants GNT_EX=1'b0 and GNT_MEM=1'b1.
- Sub-module rr_arbiter2: 2-way round-robin grant logic plus the rr_ptr flop. Inputs: CLK, RST, stall, two valids. Outputs: one-hot grant.
- The top level holds the output register, the zero filter and the optional counters.

Test Plan:
- Reset: with rf_we=1, assert RST between edges. rf_we, rf_waddr and rf_wdata go to 0 immediately. After release, with both valid, requester 0 is granted first.
- Single write: req0 with addr=5, data=0xDEADBEEF. req0_ready=1 the same cycle. Next cycle: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=0. The following cycle: rf_we=0.
- Contention: req0 (addr 3, 0x11) and req1 (addr 7, 0x22) both valid for 4 cycles. Grants go 0,1,0,1 with rf_we high for 4 consecutive cycles. rf_waddr sequence is 3,7,3,7.
- Zero filter: req1 with addr=0, data=0xFFFFFFFF. req1_ready=1, rf_we stays 0, and the next contended cycle grants requester 0.
- Stall: both valid with stall=1 for 3 cycles. Both readys are 0 and rf_we is 0. After stall drops, the grant goes to the rr_ptr value held from before the stall.
- ARB_STATS_EN: 3 grants to requester 0, 2 to requester 1, and 2 conflict cycles give grant0_cnt=3, grant1_cnt=2, conflict_cnt=2. A forced preload to 0xFFFF plus one more grant stays at 0xFFFF.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, constants and helpers for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int STAT_W = 16;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic          GNT_EX   = 1'b0;
  localparam logic          GNT_MEM  = 1'b1;

  // $zero is architecturally read-only, so a write to it must never reach the file
  function automatic logic wr_allowed(input logic [AW-1:0] addr);
    return (addr != REG_ZERO);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] cnt);
    if (cnt == {STAT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester handshakes, stall and register-file write port in one bundle.
interface regfile_write_arbiter_if;
  import regfile_arb_pkg::*;

  logic          stall;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          grant_id;

  modport master (
    output stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, grant_id
  );

  modport slave (
    input  stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, grant_id
  );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant with its priority pointer flop.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       stall,
  input  logic       valid0,
  input  logic       valid1,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    if (stall) begin
      grant = 2'b00;
    end else begin
      case ({valid1, valid0})
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer moves to the loser of each transfer; a grant implies a valid, so it is a transfer
  always_comb begin
    ptr_d = ptr_q;
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port between EX and MEM writeback.
// Optional grant/conflict statistics counters are built when ARB_STATS_EN is defined.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  regfile_write_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   grant0_cnt,
  output logic [STAT_W-1:0]   grant1_cnt,
  output logic [STAT_W-1:0]   conflict_cnt
`endif
);

  logic [1:0]    grant_s;
  logic          we_d,   we_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] data_d, data_q;
  logic          gid_d,  gid_q;

  rr_arbiter2 u_rr (
    .CLK    (CLK),
    .RST    (RST),
    .stall  (bus.stall),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant  (grant_s)
  );

  assign bus.req0_ready = grant_s[0];
  assign bus.req1_ready = grant_s[1];

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (grant_s[0]) begin
      we_d   = wr_allowed(bus.req0_addr);
      addr_d = bus.req0_addr;
      data_d = bus.req0_data;
      gid_d  = GNT_EX;
    end else if (grant_s[1]) begin
      we_d   = wr_allowed(bus.req1_addr);
      addr_d = bus.req1_addr;
      data_d = bus.req1_data;
      gid_d  = GNT_MEM;
    end else begin
      we_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q   <= 1'b0;
      addr_q <= {AW{1'b0}};
      data_q <= {DW{1'b0}};
      gid_q  <= GNT_EX;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = addr_q;
  assign bus.rf_wdata = data_q;
  assign bus.grant_id = gid_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] g0_cnt_q, g1_cnt_q, conf_cnt_q;
  logic              conflict_s;

  assign conflict_s = bus.req0_valid & bus.req1_valid & ~bus.stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      g0_cnt_q   <= {STAT_W{1'b0}};
      g1_cnt_q   <= {STAT_W{1'b0}};
      conf_cnt_q <= {STAT_W{1'b0}};
    end else begin
      g0_cnt_q   <= grant_s[0] ? sat_inc(g0_cnt_q) : g0_cnt_q;
      g1_cnt_q   <= grant_s[1] ? sat_inc(g1_cnt_q) : g1_cnt_q;
      conf_cnt_q <= conflict_s ? sat_inc(conf_cnt_q) : conf_cnt_q;
    end
  end

  assign grant0_cnt   = g0_cnt_q;
  assign grant1_cnt   = g1_cnt_q;
  assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: driver pushes expected write-port state per cycle, monitor pops and compares.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        we;
    logic        chk;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gid;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  regfile_write_arbiter_if bus ();

`ifdef ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, conflict_cnt;
  regfile_write_arbiter dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .conflict_cnt(conflict_cnt)
  );
`else
  regfile_write_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle of stimulus: readys checked live, resulting write-port state queued
  task automatic drive(input string name,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic st, input logic er0, input logic er1);
    exp_t e;
    @(negedge CLK);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.stall = st;
    #2;
    check({name, "_ready0"}, {31'd0, bus.req0_ready}, {31'd0, er0});
    check({name, "_ready1"}, {31'd0, bus.req1_ready}, {31'd0, er1});
    if (er0) e = '{we: (a0 != 5'd0), chk: 1'b1, addr: a0, data: d0, gid: 1'b0};
    else if (er1) e = '{we: (a1 != 5'd0), chk: 1'b1, addr: a1, data: d1, gid: 1'b1};
    else e = '{we: 1'b0, chk: 1'b0, addr: 5'd0, data: 32'd0, gid: 1'b0};
    sb.push_back(e);
  endtask

  task automatic idle(input string name);
    drive(name, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares registered write port one cycle after each queued expectation
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.rf_we !== e.we ||
          (e.chk && (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data || bus.grant_id !== e.gid))) begin
        n_fail++;
        $display("FAIL rf_port got we=%0b a=%0d d=%0h g=%0b expected we=%0b a=%0d d=%0h g=%0b",
                 bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_id, e.we, e.addr, e.data, e.gid);
      end
    end else if (!RST && bus.rf_we === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_write got we=1 addr=%0d expected we=0", bus.rf_waddr);
    end
  end

  initial begin
    bus.stall = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'd0;
    #3;
    check("reset_we",    {31'd0, bus.rf_we}, 32'd0);
    check("reset_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    check("reset_wdata", bus.rf_wdata, 32'd0);
    check("reset_gid",   {31'd0, bus.grant_id}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Contention from ptr=0: 0,1,0,1
    for (int i = 0; i < 4; i++)
      drive("contend", 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, (i % 2) == 0, (i % 2) == 1);
    idle("contend_idle");

    // Single write, then rf_we drops
    drive("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle("single_idle");

    // Zero filter (ptr=1 now), then contention goes to requester 0
    drive("zero", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    drive("zero_next", 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 1'b1, 1'b0);

    // Stall with ptr=1 held, then requester 1 wins
    for (int i = 0; i < 3; i++)
      drive("stall", 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b1, 1'b0, 1'b0);
    drive("unstall", 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 1'b0, 1'b1);
    idle("unstall_idle");

    // Mid-operation reset with rf_we high; ptr is 1 before reset
    drive("pre_rst", 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    bus.req0_valid = 1'b0;
    #3;
    RST = 1'b1;
    #1;
    check("midrst_we",    {31'd0, bus.rf_we}, 32'd0);
    check("midrst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    check("midrst_wdata", bus.rf_wdata, 32'd0);
    RST = 1'b0;
    drive("post_rst", 1'b1, 5'd4, 32'hA5, 1'b1, 5'd6, 32'h5A, 1'b0, 1'b1, 1'b0);
    idle("post_rst_idle");

`ifdef ARB_STATS_EN
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    drive("st_c0", 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 1'b1, 1'b0);
    drive("st_c1", 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 1'b1);
    drive("st_r0a", 1'b1, 5'd1, 32'h3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    drive("st_r0b", 1'b1, 5'd1, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    drive("st_r1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h5, 1'b0, 1'b0, 1'b1);
    idle("st_idle");
    check("grant0_cnt",   {16'd0, grant0_cnt}, 32'd3);
    check("grant1_cnt",   {16'd0, grant1_cnt}, 32'd2);
    check("conflict_cnt", {16'd0, conflict_cnt}, 32'd2);
    @(negedge CLK);
    force dut.g0_cnt_q = 16'hFFFF;
    #1;
    release dut.g0_cnt_q;
    drive("st_sat", 1'b1, 5'd1, 32'h6, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle("st_sat_idle");
    check("grant0_sat", {16'd0, grant0_cnt}, 32'h0000FFFF);
`endif

    @(negedge CLK);
    @(negedge CLK);
    #2;
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
